// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcode map, state
// encoding, PC-source select codes and small opcode classification helpers.
package ctrl_pkg;

  // Controller states; the 3-bit value is visible on the state port.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXECUTE   = 3'd1,
    ST_MEM_RD    = 3'd2,
    ST_MEM_WR    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Opcode map (low four bits of the IR opcode field).
  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SUBI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTI = 4'd8;
  localparam logic [3:0] OP_JUMP = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLL  = 4'd12;
  localparam logic [3:0] OP_HLT  = 4'd13;
  localparam logic [3:0] OP_NAND = 4'd14;
  localparam logic [3:0] OP_BLT  = 4'd15;

  // PC-source select codes.
  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Register-to-register / immediate ALU instructions that finish in WRITEBACK.
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADDI, OP_ADD, OP_SUBI, OP_SUB, OP_SLT,
      OP_SLTI, OP_SRA, OP_SLL, OP_NAND: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Conditional branches resolved in EXECUTE.
  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT);
  endfunction

  // Branch condition from the ALU flags.
  function automatic logic branch_taken(input logic [3:0] op,
                                        input logic      zf,
                                        input logic      nf);
    case (op)
      OP_BEQ:  return zf;
      OP_BNE:  return !zf;
      OP_BLT:  return nf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Bounded memory-wait counter shared by FETCH, MEM_RD and MEM_WR.
// expired is high while the count sits at TIMEOUT; TIMEOUT=0 never expires.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam bit ENABLED = (TIMEOUT != 0);

  logic [CW-1:0] cnt_reg;

  // Count waiting cycles; saturate at the limit so the disabled case stays at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = ENABLED && (cnt_reg == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 8-bit CPU: sequences fetch / execute /
// memory / writeback, drives datapath strobes, traps illegal opcodes and
// memory timeouts into a sticky FAULT, and resumes from HALT.
// Optional feature macro: CTRL_PERF_EN builds the retired-instruction counter;
// without it retired is constant 0.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             neg_flag,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             ir_write,
  output logic             alu_en,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] op;
  logic       op_illegal;
  logic       wait_expired;
  logic       waiting;

  assign op = opcode[3:0];

  // Any set bit above the 4-bit opcode map makes the instruction illegal.
  generate
    if (OPC_W > 4) begin : g_wide_opc
      assign op_illegal = |opcode[OPC_W-1:4];
    end else begin : g_narrow_opc
      assign op_illegal = 1'b0;
    end
  endgenerate

  // A wait state with the RAM not yet ready.
  assign waiting = ((state_reg == ST_FETCH) || (state_reg == ST_MEM_RD) ||
                    (state_reg == ST_MEM_WR)) && !mem_ready;

  // Any state change restarts the wait budget, so each wait state starts at 0.
  ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_next != state_reg),
    .inc    (waiting),
    .expired(wait_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; mem_ready beats the timeout when both land together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (mem_ready)         state_next = ST_EXECUTE;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_EXECUTE: begin
        if (op_illegal)          state_next = ST_FAULT;
        else if (is_alu_op(op))  state_next = ST_WRITEBACK;
        else if (op == OP_LW)    state_next = ST_MEM_RD;
        else if (op == OP_SW)    state_next = ST_MEM_WR;
        else if (op == OP_HLT)   state_next = ST_HALT;
        else                     state_next = ST_FETCH;
      end
      ST_MEM_RD: begin
        if (mem_ready)         state_next = ST_WRITEBACK;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (mem_ready)         state_next = ST_FETCH;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_WRITEBACK: state_next = ST_FETCH;
      ST_HALT: begin
        if (resume) state_next = ST_FETCH;
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  // Datapath strobes; everything is forced low while reset is asserted.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    ir_write  = 1'b0;
    alu_en    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_NEXT;
    fault     = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        ST_EXECUTE: begin
          if (!op_illegal) begin
            alu_en = 1'b1;
            if (is_branch(op)) begin
              pc_write = 1'b1;
              if (branch_taken(op, zero_flag, neg_flag)) pc_src = PC_SRC_BRANCH;
            end else if (op == OP_JUMP) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
          end
        end
        ST_MEM_RD: mem_read = 1'b1;
        ST_MEM_WR: begin
          mem_write = 1'b1;
          pc_write  = mem_ready;
        end
        ST_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        ST_HALT:  pc_write = resume;
        ST_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_reg;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] retired_reg;

  // One count per pc_write pulse, i.e. per completed instruction or resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (pc_write) begin
      retired_reg <= retired_reg + 1'b1;
    end
  end

  assign retired = retired_reg;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (OPC_W=6, TIMEOUT=4, CNT_W=2).
// Instructions are expanded into per-cycle expectation rows from the
// instruction-level rules, then applied and checked one row per cycle.
module tb_multicycle_ctrl;

  localparam int OPC_W   = 6;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MRD   = 3'd2;
  localparam logic [2:0] S_MWR   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  logic             clk = 1'b0;
  logic             rst;
  logic [OPC_W-1:0] opcode;
  logic             zero_flag, neg_flag, mem_ready, resume;
  logic             mem_read, mem_write, reg_write, ir_write, alu_en, pc_write;
  logic [1:0]       pc_src;
  logic [2:0]       state;
  logic             fault;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int ret_model = 0;
  int row_n = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .OPC_W  (OPC_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .zero_flag(zero_flag),
    .neg_flag (neg_flag),
    .mem_ready(mem_ready),
    .resume   (resume),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .ir_write (ir_write),
    .alu_en   (alu_en),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .state    (state),
    .fault    (fault),
    .retired  (retired)
  );

  // One clock cycle: inputs to drive and outputs expected in that cycle.
  typedef struct {
    logic       rst, ready, resume, zf, nf;
    logic [5:0] opc;
    logic [2:0] st;
    logic       mr, mw, rw, irw, alu, pcw;
    logic [1:0] pcs;
    logic       flt;
  } row_t;

  row_t rq[$];

  // Zero-wait single-instruction vectors: latency, PC source, register write.
  typedef struct {
    logic [5:0] opc;
    logic       zf, nf;
    int         lat;
    logic [1:0] pcs;
    logic       rw;
  } vec_t;

  vec_t vecs[12];

  // Row with random don't-care inputs and every strobe expected low.
  function automatic row_t blank(logic [2:0] st);
    row_t r;
    r.rst = 1'b0; r.ready = 1'($urandom); r.resume = 1'($urandom);
    r.zf = 1'($urandom); r.nf = 1'($urandom); r.opc = 6'($urandom);
    r.st = st; r.mr = 0; r.mw = 0; r.rw = 0; r.irw = 0; r.alu = 0; r.pcw = 0;
    r.pcs = 2'b00; r.flt = 0;
    return r;
  endfunction

  function automatic void push_fetch(int wf);
    row_t r;
    for (int i = 0; i < wf; i++) begin
      r = blank(S_FETCH); r.ready = 0; r.mr = 1; rq.push_back(r);
    end
    r = blank(S_FETCH); r.ready = 1; r.mr = 1; r.irw = 1; rq.push_back(r);
  endfunction

  function automatic row_t exec_row(logic [5:0] opc, logic zf, logic nf);
    row_t r;
    r = blank(S_EXEC); r.opc = opc; r.zf = zf; r.nf = nf;
    r.alu = (opc[5:4] == 2'b00);
    return r;
  endfunction

  function automatic void push_mem(logic [2:0] st, int wm, logic wr);
    row_t r;
    for (int i = 0; i <= wm; i++) begin
      r = blank(st); r.ready = (i == wm);
      if (wr) r.mw = 1; else r.mr = 1;
      r.pcw = wr && (i == wm);
      rq.push_back(r);
    end
  endfunction

  function automatic void push_wb();
    row_t r;
    r = blank(S_WB); r.rw = 1; r.pcw = 1; rq.push_back(r);
  endfunction

  function automatic void push_fault(int n);
    row_t r;
    for (int i = 0; i < n; i++) begin
      r = blank(S_FAULT); r.flt = 1; rq.push_back(r);
    end
  endfunction

  function automatic void push_rst(logic [2:0] cur);
    row_t r;
    r = blank(cur); r.rst = 1; rq.push_back(r);
  endfunction

  // Expand one legal instruction into its expected cycles.
  function automatic void plan_instr(logic [3:0] opc, logic zf, logic nf, int wf, int wm);
    row_t r;
    logic taken;
    push_fetch(wf);
    r = exec_row({2'b00, opc}, zf, nf);
    case (opc)
      4'd5, 4'd6, 4'd15: begin
        taken = (opc == 4'd5) ? zf : (opc == 4'd6) ? !zf : nf;
        r.pcw = 1; r.pcs = taken ? 2'b01 : 2'b00; rq.push_back(r);
      end
      4'd9: begin
        r.pcw = 1; r.pcs = 2'b10; rq.push_back(r);
      end
      4'd13: rq.push_back(r);
      4'd2: begin
        rq.push_back(r); push_mem(S_MRD, wm, 1'b0); push_wb();
      end
      4'd10: begin
        rq.push_back(r); push_mem(S_MWR, wm, 1'b1);
      end
      default: begin
        rq.push_back(r); push_wb();
      end
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] ret_exp();
`ifdef CTRL_PERF_EN
    return CNT_W'(ret_model % (1 << CNT_W));
`else
    return '0;
`endif
  endfunction

  // Apply every queued row on a negedge and check outputs 1 ns later.
  task automatic run_queue();
    row_t r;
    logic [11:0] act, exp;
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      rst = r.rst; mem_ready = r.ready; resume = r.resume;
      opcode = r.opc; zero_flag = r.zf; neg_flag = r.nf;
      #1;
      act = {state, mem_read, mem_write, reg_write, ir_write, alu_en, pc_write, pc_src, fault};
      exp = {r.st, r.mr, r.mw, r.rw, r.irw, r.alu, r.pcw, r.pcs, r.flt};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL row %0d state/strobes: got %h expected %h", row_n, act, exp);
      end
      checks++;
      if (retired !== ret_exp()) begin
        errors++;
        $display("FAIL row %0d retired: got %0d expected %0d", row_n, retired, ret_exp());
      end
      if (r.rst) ret_model = 0;
      else if (r.pcw) ret_model++;
      row_n++;
    end
  endtask

  initial begin
    int n, pulses;
    logic [1:0] pcs_seen;
    logic rw_seen, done;
    row_t r;
    logic [3:0] ropc;

    vecs[0]  = '{6'd0,  1'b0, 1'b0, 3, 2'b00, 1'b1};
    vecs[1]  = '{6'd2,  1'b0, 1'b0, 4, 2'b00, 1'b1};
    vecs[2]  = '{6'd10, 1'b0, 1'b0, 3, 2'b00, 1'b0};
    vecs[3]  = '{6'd5,  1'b1, 1'b0, 2, 2'b01, 1'b0};
    vecs[4]  = '{6'd5,  1'b0, 1'b0, 2, 2'b00, 1'b0};
    vecs[5]  = '{6'd6,  1'b0, 1'b0, 2, 2'b01, 1'b0};
    vecs[6]  = '{6'd6,  1'b1, 1'b0, 2, 2'b00, 1'b0};
    vecs[7]  = '{6'd15, 1'b0, 1'b1, 2, 2'b01, 1'b0};
    vecs[8]  = '{6'd15, 1'b1, 1'b0, 2, 2'b00, 1'b0};
    vecs[9]  = '{6'd9,  1'b0, 1'b0, 2, 2'b10, 1'b0};
    vecs[10] = '{6'd14, 1'b0, 1'b0, 3, 2'b00, 1'b1};
    vecs[11] = '{6'd7,  1'b1, 1'b1, 3, 2'b00, 1'b1};

    // Reset: strobes low even before the first edge, then FETCH with retired 0.
    rst = 1; mem_ready = 0; resume = 0; opcode = '0; zero_flag = 0; neg_flag = 0;
    #1;
    checks++;
    if ({mem_read, mem_write, reg_write, ir_write, alu_en, pc_write, pc_src, fault} !== 9'd0) begin
      errors++;
      $display("FAIL reset_strobes: got %h expected 0",
               {mem_read, mem_write, reg_write, ir_write, alu_en, pc_write, pc_src, fault});
    end
    @(negedge clk); #1;
    checks++;
    if (state !== S_FETCH) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH);
    end
    checks++;
    if (retired !== '0) begin
      errors++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    rst = 0;

    // Table-driven zero-wait instructions.
    for (int v = 0; v < 12; v++) begin
      n = 0; pulses = 0; pcs_seen = 2'b11; rw_seen = 0; done = 0;
      @(negedge clk);
      opcode = vecs[v].opc; zero_flag = vecs[v].zf; neg_flag = vecs[v].nf;
      mem_ready = 1; resume = 0;
      while (!done && n < 20) begin
        #1;
        n++;
        if (pc_write) begin pulses++; pcs_seen = pc_src; end
        if (reg_write) rw_seen = 1;
        @(posedge clk); #1;
        if (state == S_FETCH) done = 1;
        else @(negedge clk);
      end
      checks++;
      if (!done || n != vecs[v].lat) begin
        errors++;
        $display("FAIL vec%0d latency: got %0d expected %0d", v, n, vecs[v].lat);
      end
      checks++;
      if (pulses != 1) begin
        errors++; $display("FAIL vec%0d pc_write_pulses: got %0d expected 1", v, pulses);
      end
      checks++;
      if (pcs_seen !== vecs[v].pcs) begin
        errors++; $display("FAIL vec%0d pc_src: got %b expected %b", v, pcs_seen, vecs[v].pcs);
      end
      checks++;
      if (rw_seen !== vecs[v].rw) begin
        errors++; $display("FAIL vec%0d reg_write: got %b expected %b", v, rw_seen, vecs[v].rw);
      end
      ret_model++;
    end

    // Cycle-accurate sequences: start from a fresh reset.
    push_rst(S_FETCH);
    plan_instr(4'd0, 0, 0, 0, 0);
    plan_instr(4'd5, 1, 0, 0, 0);
    plan_instr(4'd5, 0, 0, 0, 0);
    plan_instr(4'd2, 0, 0, 0, 3);
    plan_instr(4'd2, 0, 0, 4, 4);
    plan_instr(4'd10, 0, 0, 4, 4);
    // hlt, ten idle cycles, then resume
    plan_instr(4'd13, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      r = blank(S_HALT); r.resume = 0; rq.push_back(r);
    end
    r = blank(S_HALT); r.resume = 1; r.pcw = 1; rq.push_back(r);
    plan_instr(4'd1, 0, 0, 1, 0);
    // reset in the middle of an lw wait
    push_fetch(0);
    rq.push_back(exec_row(6'd2, 0, 0));
    for (int i = 0; i < 2; i++) begin
      r = blank(S_MRD); r.ready = 0; r.mr = 1; rq.push_back(r);
    end
    push_rst(S_MRD);
    plan_instr(4'd3, 0, 0, 0, 0);
    // sw that never completes: timeout into sticky FAULT
    push_fetch(0);
    rq.push_back(exec_row(6'd10, 0, 0));
    for (int i = 0; i <= TIMEOUT; i++) begin
      r = blank(S_MWR); r.ready = 0; r.mw = 1; rq.push_back(r);
    end
    push_fault(6);
    push_rst(S_FAULT);
    // illegal opcode with a wide opcode field
    push_fetch(1);
    rq.push_back(exec_row(6'b010001, 0, 0));
    push_fault(3);
    push_rst(S_FAULT);
    // randomized legal instructions with bounded waits
    for (int i = 0; i < 150; i++) begin
      ropc = 4'($urandom_range(0, 15));
      if (ropc == 4'd13) ropc = 4'd0;
      plan_instr(ropc, 1'($urandom), 1'($urandom),
                 $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT));
    end
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
